// File: rtl/rank_order_spike_tx.sv
`default_nettype none
// ============================================================================
// Module   : rank_order_spike_tx
// Brief    : Latches a sorted pixel ranking and replays it, rank 0 first, as
//            four-phase AER events (rank-order / time-to-first-spike coding).
// Revision : 1.0 - initial release
// ============================================================================
module rank_order_spike_tx #(
    parameter int IMAGE_SIZE  = 5,
    parameter int IDX_BITS    = $clog2(IMAGE_SIZE),
    parameter int MAX_SPIKES  = IMAGE_SIZE,
    parameter int ADDR_BITS   = 8,
    parameter int ADDR_OFFSET = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [IDX_BITS-1:0]  sorted_indexes [0:IMAGE_SIZE-1],
    input  logic                 sort_done,
    output logic                 tx_ready,
    output logic [ADDR_BITS-1:0] AERIN_ADDR,
    output logic                 AERIN_REQ,
    input  logic                 AERIN_ACK,
    output logic                 tx_done,
    output logic [IDX_BITS:0]    spike_cnt
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_REQ    = 2'd1;
    localparam logic [1:0] c_ST_ACKLOW = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    localparam logic [IDX_BITS-1:0]  c_LAST_RANK = IDX_BITS'(MAX_SPIKES - 1);
    localparam logic [IDX_BITS-1:0]  c_RANK_ONE  = IDX_BITS'(1);
    localparam logic [IDX_BITS:0]    c_CNT_ONE   = (IDX_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] c_OFFSET    = ADDR_BITS'(ADDR_OFFSET);

    logic [1:0]           r_state;
    logic [IDX_BITS-1:0]  r_buf [0:IMAGE_SIZE-1];
    logic [IDX_BITS-1:0]  r_rank;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_req;
    logic                 r_done;
    logic                 r_ready;
    logic [IDX_BITS:0]    r_cnt;
    logic [IDX_BITS-1:0]  w_next_rank;

    // Index is zero-extended before the offset is added; the sum wraps.
    function automatic logic [ADDR_BITS-1:0] f_addr(input logic [IDX_BITS-1:0] idx);
        return ADDR_BITS'(idx) + c_OFFSET;
    endfunction

    assign w_next_rank = r_rank + c_RANK_ONE;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= c_ST_IDLE;
            r_rank  <= '0;
            r_addr  <= '0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
            r_cnt   <= '0;
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (sort_done) begin
                        r_buf   <= sorted_indexes;
                        r_rank  <= '0;
                        r_cnt   <= '0;
                        r_addr  <= f_addr(sorted_indexes[0]);
                        r_req   <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (AERIN_ACK) begin
                        r_req   <= 1'b0;
                        r_cnt   <= r_cnt + c_CNT_ONE;
                        r_state <= c_ST_ACKLOW;
                    end
                end
                c_ST_ACKLOW: begin
                    // Next request only once the previous ACK has been released.
                    if (!AERIN_ACK) begin
                        if (r_rank == c_LAST_RANK) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_rank  <= w_next_rank;
                            r_addr  <= f_addr(r_buf[w_next_rank]);
                            r_req   <= 1'b1;
                            r_state <= c_ST_REQ;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = r_ready;
    assign AERIN_ADDR = r_addr;
    assign AERIN_REQ  = r_req;
    assign tx_done    = r_done;
    assign spike_cnt  = r_cnt;

endmodule
`default_nettype wire
